// File: rtl/pal_chroma_modulator.sv
`default_nettype none
// pal_chroma_modulator: PAL quadrature chroma modulator with per-line V switch and +/-135 deg burst.
// Rev 1.0
module pal_chroma_modulator #(
  parameter logic [31:0] PHASE_INC = 32'd396713490,
  parameter int          BURST_AMP = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [5:0] u_in,
  input  logic signed [5:0] v_in,
  input  logic              line_start,
  input  logic              burst_en,
  input  logic              active,
  output logic signed [7:0] chroma_out,
  output logic              v_switch
);

  localparam logic signed [5:0] BURST_POS = 6'(BURST_AMP);
  localparam logic signed [5:0] BURST_NEG = -BURST_POS;

  // First quadrant of round(127*sin(2*pi*k/256)), k = 0..64.
  localparam logic [6:0] QTAB [0:64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
    7'd127
  };

  function automatic logic signed [7:0] sine(input logic [7:0] k);
    logic [6:0] j;
    logic [7:0] mag;
    j    = k[6] ? (7'd64 - {1'b0, k[5:0]}) : {1'b0, k[5:0]};
    mag  = {1'b0, QTAB[j]};
    sine = k[7] ? -$signed(mag) : $signed(mag);
  endfunction

  logic [31:0]        phase;
  logic [7:0]         cos_idx;
  logic               switch_next;
  logic signed [5:0]  u_sel, v_sel;

  logic signed [5:0]  u_s1, v_s1;
  logic               sw_s1;
  logic signed [7:0]  sin_s1, cos_s1;

  logic signed [13:0] prod_u, prod_v_raw, prod_v;
  logic signed [13:0] prod_u_s2, prod_v_s2;
  logic [14:0]        sum;

  assign cos_idx = phase[31:24] + 8'd64;

  always_comb begin
    switch_next = v_switch ^ line_start;
    u_sel       = '0;
    v_sel       = '0;
    if (burst_en) begin
      u_sel = BURST_NEG;
      v_sel = BURST_POS;
    end else if (active) begin
      u_sel = u_in;
      v_sel = v_in;
    end
  end

  assign prod_u     = $signed({{8{u_s1[5]}}, u_s1}) * $signed({{6{sin_s1[7]}}, sin_s1});
  assign prod_v_raw = $signed({{8{v_s1[5]}}, v_s1}) * $signed({{6{cos_s1[7]}}, cos_s1});
  assign prod_v     = sw_s1 ? -prod_v_raw : prod_v_raw;
  // Round-half-up then keep bits [14:7]: equivalent to (sum + 64) >>> 7.
  assign sum        = {prod_u_s2[13], prod_u_s2} + {prod_v_s2[13], prod_v_s2} + 15'd64;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= '0;
      v_switch   <= 1'b0;
      u_s1       <= '0;
      v_s1       <= '0;
      sw_s1      <= 1'b0;
      sin_s1     <= '0;
      cos_s1     <= '0;
      prod_u_s2  <= '0;
      prod_v_s2  <= '0;
      chroma_out <= '0;
    end else begin
      phase      <= phase + PHASE_INC;
      v_switch   <= switch_next;
      u_s1       <= u_sel;
      v_s1       <= v_sel;
      sw_s1      <= switch_next;
      sin_s1     <= sine(phase[31:24]);
      cos_s1     <= sine(cos_idx);
      prod_u_s2  <= prod_u;
      prod_v_s2  <= prod_v;
      chroma_out <= sum[14:7];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pal_chroma_modulator.sv
`default_nettype none
// tb_pal_chroma_modulator: directed and randomized checks against a trigonometric reference model.
// Rev 1.0
module tb_pal_chroma_modulator;

  localparam logic [31:0] INC_A = 32'h4000_0000;
  localparam int          AMP_A = 8;
  localparam logic [31:0] INC_B = 32'd396713490;
  localparam int          AMP_B = 6;
  localparam real         PI    = 3.14159265358979323846;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic signed [5:0] u_in = '0;
  logic signed [5:0] v_in = '0;
  logic              line_start = 1'b0;
  logic              burst_en = 1'b0;
  logic              active = 1'b0;
  logic signed [7:0] chroma_a, chroma_b;
  logic              vsw_a, vsw_b;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int unsigned ph_a, ph_b;
  bit          sw_m;
  int          pa[3];
  int          pb[3];

  pal_chroma_modulator #(.PHASE_INC(INC_A), .BURST_AMP(AMP_A)) dut_a (
    .clk(clk), .rst(rst), .u_in(u_in), .v_in(v_in), .line_start(line_start),
    .burst_en(burst_en), .active(active), .chroma_out(chroma_a), .v_switch(vsw_a)
  );

  pal_chroma_modulator #(.PHASE_INC(INC_B), .BURST_AMP(AMP_B)) dut_b (
    .clk(clk), .rst(rst), .u_in(u_in), .v_in(v_in), .line_start(line_start),
    .burst_en(burst_en), .active(active), .chroma_out(chroma_b), .v_switch(vsw_b)
  );

  always #5 clk = ~clk;

  function automatic int lut(int k);
    real r;
    r = 127.0 * $sin(2.0 * PI * real'(k % 256) / 256.0);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else return -$rtoi(-r + 0.5);
  endfunction

  function automatic int chroma_of(int unsigned ph, int amp, bit sw);
    int idx, u, v, t;
    idx = int'(ph >> 24);
    if (burst_en) begin u = -amp; v = amp; end
    else if (active) begin u = int'(u_in); v = int'(v_in); end
    else begin u = 0; v = 0; end
    t = u * lut(idx) + (sw ? -(v * lut(idx + 64)) : v * lut(idx + 64));
    return (t + 64) >>> 7;
  endfunction

  // Advance one clock: update the model with the sample taken at this edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      ph_a = 0; ph_b = 0; sw_m = 1'b0;
      pa = '{0, 0, 0};
      pb = '{0, 0, 0};
    end else begin
      sw_m = sw_m ^ line_start;
      pa[2] = pa[1]; pa[1] = pa[0]; pa[0] = chroma_of(ph_a, AMP_A, sw_m);
      pb[2] = pb[1]; pb[1] = pb[0]; pb[0] = chroma_of(ph_b, AMP_B, sw_m);
      ph_a = ph_a + INC_A;
      ph_b = ph_b + INC_B;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; line_start = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      rst = 1'b1;
      u_in = 6'($urandom); v_in = 6'($urandom);
      active = 1'($urandom); burst_en = 1'($urandom);
      line_start = (i == 1) ? 1'b1 : 1'($urandom);
      tick();
      checks++;
      if (chroma_a !== 8'sd0 || chroma_b !== 8'sd0 || vsw_a !== 1'b0 || vsw_b !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d chroma_a=%0d chroma_b=%0d vsw=%b%b required 0 0 00",
                 i, chroma_a, chroma_b, vsw_a, vsw_b);
      end
    end
    rst = 1'b0; line_start = 1'b0; burst_en = 1'b0; active = 1'b1;
    u_in = 6'sd31; v_in = 6'sd20;
    tick();
    checks++;
    if (chroma_a !== 8'sd0 || chroma_b !== 8'sd0 || vsw_a !== 1'b0) begin
      failures++;
      $display("FAIL reset_after chroma_a=%0d chroma_b=%0d vsw=%b required 0 0 0", chroma_a, chroma_b, vsw_a);
    end
    tick();
    tick();
    checks++;
    if (chroma_a !== 8'sd20 || chroma_b !== 8'sd20) begin
      failures++;
      $display("FAIL reset_first_phase chroma_a=%0d chroma_b=%0d required 20 20", chroma_a, chroma_b);
    end
  endtask

  task automatic test_u_axis();
    int pat[4] = '{0, 31, 0, -31};
    do_reset();
    active = 1'b1; burst_en = 1'b0; u_in = 6'sd31; v_in = 6'sd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 2) begin
        checks++;
        if (chroma_a !== 8'(pat[(i - 2) % 4]) || chroma_b !== 8'(pb[2])) begin
          failures++;
          $display("FAIL u_axis i=%0d chroma_a=%0d req %0d chroma_b=%0d req %0d",
                   i, chroma_a, pat[(i - 2) % 4], chroma_b, pb[2]);
        end
      end
    end
  endtask

  task automatic test_v_switch();
    int pat[4] = '{20, 0, -20, 0};
    int j, e;
    do_reset();
    active = 1'b1; burst_en = 1'b0; u_in = 6'sd0; v_in = 6'sd20;
    for (int i = 0; i < 14; i++) begin
      line_start = (i == 6);
      tick();
      checks++;
      if (vsw_a !== (i >= 6) || vsw_b !== (i >= 6)) begin
        failures++;
        $display("FAIL v_switch_state i=%0d vsw=%b%b required %0d", i, vsw_a, vsw_b, i >= 6);
      end
      if (i >= 2) begin
        j = i - 2;
        e = (j >= 6) ? -pat[j % 4] : pat[j % 4];
        checks++;
        if (chroma_a !== 8'(e) || chroma_b !== 8'(pb[2])) begin
          failures++;
          $display("FAIL v_axis j=%0d chroma_a=%0d req %0d chroma_b=%0d req %0d",
                   j, chroma_a, e, chroma_b, pb[2]);
        end
      end
    end
    line_start = 1'b0;
  endtask

  task automatic test_burst_priority();
    int pat0[4] = '{8, -8, -8, 8};
    int pat1[4] = '{-8, -8, 8, 8};
    int j, e;
    do_reset();
    active = 1'b1; burst_en = 1'b1; u_in = 6'sd31; v_in = 6'sd31;
    for (int i = 0; i < 16; i++) begin
      line_start = (i == 8);
      tick();
      if (i >= 2) begin
        j = i - 2;
        e = (j >= 8) ? pat1[j % 4] : pat0[j % 4];
        checks++;
        if (chroma_a !== 8'(e) || chroma_b !== 8'(pb[2])) begin
          failures++;
          $display("FAIL burst j=%0d chroma_a=%0d req %0d chroma_b=%0d req %0d",
                   j, chroma_a, e, chroma_b, pb[2]);
        end
      end
    end
    line_start = 1'b0; burst_en = 1'b0;
  endtask

  task automatic test_blanking();
    do_reset();
    active = 1'b0; burst_en = 1'b0; u_in = -6'sd32; v_in = 6'sd31;
    // samples 0..5 blank, 6..11 burst, 12.. blank again
    for (int i = 0; i < 18; i++) begin
      burst_en = (i >= 6 && i < 12);
      tick();
      if (i >= 2) begin
        checks++;
        if ((i - 2 < 6 || i - 2 >= 12) && chroma_a !== 8'sd0) begin
          failures++;
          $display("FAIL blank_zero j=%0d chroma_a=%0d required 0", i - 2, chroma_a);
        end else if (chroma_a !== 8'(pa[2]) || chroma_b !== 8'(pb[2])) begin
          failures++;
          $display("FAIL blank_model j=%0d chroma_a=%0d req %0d chroma_b=%0d req %0d",
                   i - 2, chroma_a, pa[2], chroma_b, pb[2]);
        end
      end
      if (i == 13) begin
        checks++;
        if (chroma_a === 8'sd0) begin
          failures++;
          $display("FAIL burst_tail chroma_a=%0d required nonzero (last burst sample)", chroma_a);
        end
      end
    end
  endtask

  task automatic test_simultaneous();
    rst = 1'b1; line_start = 1'b1;
    tick();
    checks++;
    if (vsw_a !== 1'b0 || vsw_b !== 1'b0) begin
      failures++;
      $display("FAIL rst_vs_line_start vsw=%b%b required 00", vsw_a, vsw_b);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (vsw_a !== 1'b1) begin
      failures++;
      $display("FAIL back_to_back_1 vsw=%b required 1", vsw_a);
    end
    tick();
    line_start = 1'b0;
    checks++;
    if (vsw_a !== 1'b0 || vsw_b !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_2 vsw=%b%b required 00", vsw_a, vsw_b);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      line_start = ($urandom_range(0, 15) == 0);
      burst_en   = ($urandom_range(0, 7) == 0);
      active     = 1'($urandom);
      u_in       = 6'($urandom);
      v_in       = 6'($urandom);
      tick();
      checks++;
      if (chroma_a !== 8'(pa[2]) || chroma_b !== 8'(pb[2]) || vsw_a !== sw_m || vsw_b !== sw_m) begin
        failures++;
        $display("FAIL random i=%0d chroma_a=%0d req %0d chroma_b=%0d req %0d vsw=%b%b req %b",
                 i, chroma_a, pa[2], chroma_b, pb[2], vsw_a, vsw_b, sw_m);
      end
    end
    rst = 1'b0; line_start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_u_axis();
    test_v_switch();
    test_burst_priority();
    test_blanking();
    test_simultaneous();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
